// File: rtl/free_list_ckpt_pkg.sv
// Shared defaults, width derivations and tag type for the physical-register free list.
package free_list_ckpt_pkg;

  localparam int DEF_N_WAY  = 2;
  localparam int DEF_N_PHYS = 64;
  localparam int DEF_N_ARCH = 32;
  localparam int DEF_N_CKPT = 4;

  // Tag 0 is the null tag, so N_PHYS+1 codes are needed.
  function automatic int calc_tag_w(input int n_phys);
    return $clog2(n_phys + 1);
  endfunction

  // One extra MSB on each pointer tells a full FIFO from an empty one.
  function automatic int calc_ptr_w(input int n_free);
    return $clog2(n_free) + 1;
  endfunction

  localparam int DEF_TAG_W = calc_tag_w(DEF_N_PHYS);
  localparam int DEF_PTR_W = calc_ptr_w(DEF_N_PHYS - DEF_N_ARCH);

  typedef logic [DEF_TAG_W-1:0] tag_t;

endpackage

// File: rtl/free_list_compact.sv
// Packs the valid, non-null retire tags to the low slots (lowest port first) and counts them.
module free_list_compact #(
  parameter int N_WAY = 2,
  parameter int TAG_W = 7,
  localparam int CNT_W = $clog2(N_WAY) + 1
) (
  input  logic [N_WAY-1:0]            valid,
  input  logic [N_WAY-1:0][TAG_W-1:0] tags,
  output logic [N_WAY-1:0][TAG_W-1:0] packed_tags,
  output logic [CNT_W-1:0]            count
);

  logic [CNT_W-1:0] n;

  // NOTE: every variable assigned in an always_comb gets a default first,
  // otherwise paths that skip the assignment infer a latch.
  always_comb begin
    packed_tags = '0;
    n           = '0;
    for (int p = 0; p < N_WAY; p++) begin
      if (valid[p] && (tags[p] != '0)) begin
        for (int j = 0; j < N_WAY; j++) begin
          if (CNT_W'(j) == n) packed_tags[j] = tags[p];
        end
        n = n + CNT_W'(1);
      end
    end
  end

  assign count = n;

endmodule

// File: rtl/free_list_ckpt.sv
// Circular free list of physical register tags with branch checkpoints of the head pointer.
module free_list_ckpt
  import free_list_ckpt_pkg::*;
#(
  parameter int N_WAY  = DEF_N_WAY,
  parameter int N_PHYS = DEF_N_PHYS,
  parameter int N_ARCH = DEF_N_ARCH,
  parameter int N_CKPT = DEF_N_CKPT,
  localparam int TAG_W  = calc_tag_w(N_PHYS),
  localparam int N_FREE = N_PHYS - N_ARCH,
  localparam int PTR_W  = calc_ptr_w(N_FREE),
  localparam int IDX_W  = PTR_W - 1,
  localparam int CNT_W  = $clog2(N_WAY) + 1,
  localparam int CID_W  = $clog2(N_CKPT)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [CNT_W-1:0]            alloc_num,
  output logic [N_WAY-1:0][TAG_W-1:0] alloc_tags,
  output logic [CNT_W-1:0]            free_num,
  output logic [PTR_W-1:0]            free_count,
  input  logic [N_WAY-1:0]            ret_valid,
  input  logic [N_WAY-1:0][TAG_W-1:0] ret_tags,
  input  logic                        ckpt_save,
  input  logic [CID_W-1:0]            ckpt_save_id,
  input  logic                        ckpt_restore,
  input  logic [CID_W-1:0]            ckpt_restore_id,
  output logic                        err
);

  logic [TAG_W-1:0] fifo_q [N_FREE];
  logic [PTR_W-1:0] ckpt_q [N_CKPT];
  logic [PTR_W-1:0] head_q, tail_q;
  logic             err_q;

  logic [PTR_W-1:0]            count;
  logic [N_WAY-1:0][TAG_W-1:0] ret_packed;
  logic [CNT_W-1:0]            ret_cnt;
  logic                        alloc_over, ret_over;
  logic [CNT_W-1:0]            alloc_eff, wr_num;
  logic [PTR_W-1:0]            head_d, tail_d, occ, space;
  logic                        err_d;

  free_list_compact #(
    .N_WAY (N_WAY),
    .TAG_W (TAG_W)
  ) u_compact (
    .valid       (ret_valid),
    .tags        (ret_tags),
    .packed_tags (ret_packed),
    .count       (ret_cnt)
  );

  // Outputs come from registered state only; alloc_num never reaches alloc_tags.
  always_comb begin
    count      = tail_q - head_q;
    free_count = count;
    free_num   = (count >= PTR_W'(N_WAY)) ? CNT_W'(N_WAY) : CNT_W'(count);
    for (int i = 0; i < N_WAY; i++) begin
      alloc_tags[i] = fifo_q[head_q[IDX_W-1:0] + IDX_W'(i)];
    end
    err = err_q;
  end

  // Restore overrides allocation; retire capacity is judged against the new head.
  always_comb begin
    alloc_over = (alloc_num > free_num);
    alloc_eff  = alloc_over ? free_num : alloc_num;
    head_d     = ckpt_restore ? ckpt_q[ckpt_restore_id] : head_q + PTR_W'(alloc_eff);
    occ        = tail_q - head_d;
    space      = (occ > PTR_W'(N_FREE)) ? '0 : PTR_W'(N_FREE) - occ;
    ret_over   = (PTR_W'(ret_cnt) > space);
    wr_num     = ret_over ? CNT_W'(space) : ret_cnt;
    tail_d     = tail_q + PTR_W'(wr_num);
    err_d      = err_q | (alloc_over & ~ckpt_restore) | ret_over;
  end

  // NOTE: the FIFO and checkpoint storage are reset because the list must
  // come up holding exactly the unmapped tags N_ARCH+1..N_PHYS.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_FREE; i++) fifo_q[i] <= TAG_W'(N_ARCH + 1 + i);
      for (int c = 0; c < N_CKPT; c++) ckpt_q[c] <= '0;
      head_q <= '0;
      tail_q <= PTR_W'(N_FREE);
      err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed by the combinational blocks.
      head_q <= head_d;
      tail_q <= tail_d;
      err_q  <= err_d;
      for (int k = 0; k < N_WAY; k++) begin
        if (CNT_W'(k) < wr_num) fifo_q[tail_q[IDX_W-1:0] + IDX_W'(k)] <= ret_packed[k];
      end
      if (ckpt_save) ckpt_q[ckpt_save_id] <= head_d;
    end
  end

endmodule

// File: tb/tb_free_list_ckpt.sv
// Directed self-checking bench for free_list_ckpt with default parameters.
module tb_free_list_ckpt;
  import free_list_ckpt_pkg::*;

  localparam int N_WAY = DEF_N_WAY;
  localparam int TAG_W = DEF_TAG_W;
  localparam int PTR_W = DEF_PTR_W;
  localparam int CNT_W = $clog2(N_WAY) + 1;
  localparam int CID_W = $clog2(DEF_N_CKPT);

  logic                        clock;
  logic                        reset;
  logic [CNT_W-1:0]            alloc_num;
  logic [N_WAY-1:0][TAG_W-1:0] alloc_tags;
  logic [CNT_W-1:0]            free_num;
  logic [PTR_W-1:0]            free_count;
  logic [N_WAY-1:0]            ret_valid;
  logic [N_WAY-1:0][TAG_W-1:0] ret_tags;
  logic                        ckpt_save;
  logic [CID_W-1:0]            ckpt_save_id;
  logic                        ckpt_restore;
  logic [CID_W-1:0]            ckpt_restore_id;
  logic                        err;

  int n_cmp = 0;
  int n_bad = 0;

  free_list_ckpt dut (
    .clock           (clock),
    .reset           (reset),
    .alloc_num       (alloc_num),
    .alloc_tags      (alloc_tags),
    .free_num        (free_num),
    .free_count      (free_count),
    .ret_valid       (ret_valid),
    .ret_tags        (ret_tags),
    .ckpt_save       (ckpt_save),
    .ckpt_save_id    (ckpt_save_id),
    .ckpt_restore    (ckpt_restore),
    .ckpt_restore_id (ckpt_restore_id),
    .err             (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_num       = '0;
    ret_valid       = '0;
    ret_tags        = '0;
    ckpt_save       = 1'b0;
    ckpt_save_id    = '0;
    ckpt_restore    = 1'b0;
    ckpt_restore_id = '0;
  endtask

  task automatic check_head(input string tag, input int t0, input int cnt, input int e);
    check({tag, "_tag0"}, 32'(alloc_tags[0]), 32'(t0));
    check({tag, "_count"}, 32'(free_count), 32'(cnt));
    check({tag, "_err"}, 32'(err), 32'(e));
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset contents
    check("rst_tag0", 32'(alloc_tags[0]), 33);
    check("rst_tag1", 32'(alloc_tags[1]), 34);
    check("rst_free_num", 32'(free_num), 2);
    check("rst_count", 32'(free_count), 32);
    check("rst_err", 32'(err), 0);

    // Drain the list two tags per cycle
    alloc_num = 2;
    for (int c = 0; c < 16; c++) begin
      check("drain_tag0", 32'(alloc_tags[0]), 32'(33 + 2 * c));
      check("drain_tag1", 32'(alloc_tags[1]), 32'(34 + 2 * c));
      tick();
    end
    alloc_num = 0;
    check("empty_count", 32'(free_count), 0);
    check("empty_free_num", 32'(free_num), 0);
    check("empty_err", 32'(err), 0);

    // Over-allocation on empty list
    alloc_num = 1;
    tick();
    alloc_num = 0;
    check_head("overalloc", 33, 0, 1);

    // Retire into empty list: no bypass, visible next cycle
    ret_valid   = 2'b11;
    ret_tags[0] = 5;
    ret_tags[1] = 7;
    #1 check("nobypass_free_num", 32'(free_num), 0);
    tick();
    ret_valid = '0;
    check("ret_tag0", 32'(alloc_tags[0]), 5);
    check("ret_tag1", 32'(alloc_tags[1]), 7);
    check("ret_count", 32'(free_count), 2);

    // Port 0 valid with null tag is skipped, port 1 compacts down
    ret_valid   = 2'b11;
    ret_tags[0] = 0;
    ret_tags[1] = 9;
    tick();
    ret_valid = '0;
    check("compact_count", 32'(free_count), 3);
    check("compact_tag0", 32'(alloc_tags[0]), 5);
    alloc_num = 2;
    tick();
    alloc_num = 0;
    check("compact_next_tag", 32'(alloc_tags[0]), 9);
    check("compact_free_num", 32'(free_num), 1);

    // Asynchronous reset in the middle of a restore/alloc/retire cycle
    alloc_num       = 2;
    ckpt_restore    = 1'b1;
    ckpt_restore_id = 2;
    ret_valid       = 2'b11;
    ret_tags[0]     = 1;
    ret_tags[1]     = 2;
    #2 reset = 1'b1;
    #1;
    check("async_tag0", 32'(alloc_tags[0]), 33);
    check("async_tag1", 32'(alloc_tags[1]), 34);
    check("async_count", 32'(free_count), 32);
    check("async_err", 32'(err), 0);
    tick();
    idle_inputs();
    reset = 1'b0;

    // Checkpoint save on the first edge after reset, then restore with retires
    alloc_num    = 2;
    ckpt_save    = 1'b1;
    ckpt_save_id = 1;
    tick();
    ckpt_save = 1'b0;
    check_head("first_edge", 35, 30, 0);
    repeat (3) tick();
    check_head("pre_restore", 41, 24, 0);
    ckpt_restore    = 1'b1;
    ckpt_restore_id = 1;
    ret_valid       = 2'b11;
    ret_tags[0]     = 3;
    ret_tags[1]     = 4;
    tick();
    idle_inputs();
    check_head("restore", 35, 32, 0);
    check("restore_tag1", 32'(alloc_tags[1]), 36);

    // Retire into a full list drops the tag and flags an error
    ret_valid   = 2'b01;
    ret_tags[0] = 10;
    tick();
    idle_inputs();
    check_head("overflow", 35, 32, 1);

    // Save and restore in the same cycle: restore wins, slot gets restored head
    alloc_num    = 2;
    ckpt_save    = 1'b1;
    ckpt_save_id = 3;
    tick();
    check("save3_tag0", 32'(alloc_tags[0]), 37);
    ckpt_save_id    = 0;
    ckpt_restore    = 1'b1;
    ckpt_restore_id = 1;
    tick();
    idle_inputs();
    check("both_tag0", 32'(alloc_tags[0]), 35);
    check("both_count", 32'(free_count), 32);
    alloc_num = 2;
    tick();
    alloc_num       = 0;
    ckpt_restore    = 1'b1;
    ckpt_restore_id = 0;
    tick();
    check("slot0_tag0", 32'(alloc_tags[0]), 35);
    ckpt_restore_id = 3;
    tick();
    idle_inputs();
    check("slot3_tag0", 32'(alloc_tags[0]), 37);
    check("slot3_count", 32'(free_count), 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/free_list_ckpt.md
FREE_LIST_CKPT -- requirements
Module: free_list_ckpt

Interface
REQ-001 SHALL have parameter N_WAY, default 2, dispatch/retire ports per cycle.
REQ-002 SHALL have parameter N_PHYS, default 64, physical registers; tag 0 = null, valid tags 1..N_PHYS.
REQ-003 SHALL have parameter N_ARCH, default 32, architectural registers; tags 1..N_ARCH are mapped at reset.
REQ-004 SHALL have parameter N_CKPT, default 4, branch checkpoint slots.
REQ-005 SHALL derive TAG_W=$clog2(N_PHYS+1), N_FREE=N_PHYS-N_ARCH (power of two), PTR_W=$clog2(N_FREE)+1 (MSB is wrap bit).
REQ-006 clock  in  1  sole clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 alloc_num  in  $clog2(N_WAY)+1  tags consumed this cycle, 0..N_WAY.
REQ-009 alloc_tags  out  N_WAY x TAG_W  next free tags in FIFO order; slot i valid when i < free_num.
REQ-010 free_num  out  $clog2(N_WAY)+1  min(count, N_WAY).
REQ-011 free_count  out  PTR_W  total entries held, 0..N_FREE.
REQ-012 ret_valid  in  N_WAY  per-port retire strobe.
REQ-013 ret_tags  in  N_WAY x TAG_W  told tags released at retire.
REQ-014 ckpt_save  in  1  snapshot head pointer.
REQ-015 ckpt_save_id  in  $clog2(N_CKPT)  snapshot slot.
REQ-016 ckpt_restore  in  1  mispredict recovery.
REQ-017 ckpt_restore_id  in  $clog2(N_CKPT)  slot to restore.
REQ-018 err  out  1  sticky: over-allocation or overflow seen.

Function
REQ-019 SHALL store tags in an N_FREE-entry circular FIFO with head (alloc) and tail (free) pointers, PTR_W bits each.
REQ-020 SHALL drive alloc_tags[i] = fifo[(head+i) mod N_FREE] combinationally from registered state; alloc_num has no combinational path to alloc_tags.
REQ-021 SHALL advance head by alloc_num at the clock edge; alloc_num > free_num SHALL clamp to free_num and set err.
REQ-022 SHALL compact valid ret ports with nonzero tag (lowest port first) and write them at tail, tail+1, ...; advance tail by the number written.
REQ-023 ret_valid with ret_tag==0 SHALL be ignored (no write, no err).
REQ-024 Retired tags SHALL become visible on alloc_tags the cycle after retire; no same-cycle bypass.
REQ-025 count = tail-head (PTR_W modular); full when count==N_FREE, empty when 0.
REQ-026 A retire that would make count > N_FREE SHALL drop excess tags and set err.
REQ-027 ckpt_save SHALL record the post-allocation head of that cycle (head+alloc_num) in slot ckpt_save_id.
REQ-028 ckpt_restore SHALL set head to the saved slot value, overriding alloc_num that cycle (alloc ignored, no err); retires that cycle SHALL still apply to tail.
REQ-029 ckpt_save and ckpt_restore in the same cycle: restore wins; the save slot is written with the restored head.
REQ-030 Pointers SHALL wrap modulo 2*N_FREE; the wrap bit distinguishes full from empty.
REQ-031 Outputs SHALL depend on registered state only (free_num, free_count, alloc_tags, err).

Reset
REQ-032 On reset: fifo[i]=N_ARCH+1+i, head=0, tail=0 with wrap bit set (count=N_FREE), all checkpoint slots=0, err=0.
REQ-033 Reset SHALL take effect immediately and asynchronously, abandoning any in-flight alloc/retire/restore; the first edge after deassertion operates on reset state.

Structure
REQ-034 Shared package SHALL hold N_WAY, N_PHYS, N_ARCH, N_CKPT defaults, TAG_W/PTR_W derivation and the tag_t typedef.
REQ-035 Retire-port compaction (valid mask -> packed tag vector + count) SHALL be a sub-module free_list_compact.
REQ-036 Total RTL SHALL be a single always_ff for state plus combinational next-state logic; no latches.

Verification
REQ-037 Reset, alloc_num=0 -> alloc_tags={33,34}, free_num=2, free_count=32, err=0.
REQ-038 alloc_num=2 for 16 cycles -> tags 33..64 in order, then free_count=0, free_num=0; alloc_num=1 next -> err=1, head unchanged.
REQ-039 Empty list, ret_valid=2'b11 ret_tags={5,7} -> next cycle alloc_tags={5,7}, free_count=2; same-cycle alloc sees none.
REQ-040 ret_valid=2'b10 ret_tags={9,0} -> compacted: one tag 9 written at tail, free_count +1.
REQ-041 After reset: save slot1 with alloc_num=2, alloc 6 more, restore slot1 with ret {3,4} -> alloc_tags={35,36}, free_count=30+2=32 minus 0 held... i.e. free_count=32 (30 free + 2 retired), err=0.
REQ-042 Assert reset mid-restore with alloc_num=2 -> state equals REQ-032 immediately, no err.
